// File: rtl/sender_wrapper_pkg.sv
// rtl/sender_wrapper_pkg.sv - shared constants and serializer state encoding for the UART transmit path
package sender_wrapper_pkg;

  localparam int SENDER_PERIOD_DEFAULT = 1292;
  localparam int DEPTH_LOG_DEFAULT     = 10;

  typedef enum logic [1:0] {
    SENDER_IDLE,
    SENDER_START,
    SENDER_DATA,
    SENDER_STOP
  } sender_state_t;

endpackage

// File: rtl/sender.sv
// rtl/sender.sv - 8N1 serializer with byte/valid/ready input and registered tx line
module sender
  import sender_wrapper_pkg::*;
#(
  parameter int SENDER_PERIOD = SENDER_PERIOD_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       active,
  output logic       tx
);

  localparam int CYC_W = $clog2(SENDER_PERIOD);
  localparam logic [CYC_W-1:0] LAST = CYC_W'(SENDER_PERIOD - 1);

  sender_state_t    state, state_n;
  logic [CYC_W-1:0] cyc, cyc_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       sh, sh_n;
  logic             tx_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SENDER_IDLE;
      cyc   <= '0;
      idx   <= '0;
      sh    <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      cyc   <= cyc_n;
      idx   <= idx_n;
      sh    <= sh_n;
      tx    <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    cyc_n   = cyc;
    idx_n   = idx;
    sh_n    = sh;
    case (state)
      SENDER_IDLE: begin
        if (valid) begin
          sh_n    = data;
          cyc_n   = '0;
          state_n = SENDER_START;
        end
      end
      SENDER_START: begin
        if (cyc == LAST) begin
          cyc_n   = '0;
          idx_n   = '0;
          state_n = SENDER_DATA;
        end else begin
          cyc_n = cyc + CYC_W'(1);
        end
      end
      SENDER_DATA: begin
        if (cyc == LAST) begin
          cyc_n = '0;
          sh_n  = {1'b0, sh[7:1]};
          idx_n = idx + 3'd1;
          if (idx == 3'd7) state_n = SENDER_STOP;
        end else begin
          cyc_n = cyc + CYC_W'(1);
        end
      end
      SENDER_STOP: begin
        // A waiting byte is taken here so frames run back-to-back.
        if (cyc == LAST) begin
          cyc_n = '0;
          if (valid) begin
            sh_n    = data;
            state_n = SENDER_START;
          end else begin
            state_n = SENDER_IDLE;
          end
        end else begin
          cyc_n = cyc + CYC_W'(1);
        end
      end
      default: state_n = SENDER_IDLE;
    endcase
  end

  always_comb begin
    ready  = (state == SENDER_IDLE) || ((state == SENDER_STOP) && (cyc == LAST));
    active = (state != SENDER_IDLE);
    case (state_n)
      SENDER_START: tx_n = 1'b0;
      SENDER_DATA:  tx_n = sh_n[0];
      default:      tx_n = 1'b1;
    endcase
  end

endmodule

// File: rtl/sender_wrapper.sv
// rtl/sender_wrapper.sv - byte FIFO in front of the UART serializer, with full/busy/overflow status
module sender_wrapper
  import sender_wrapper_pkg::*;
#(
  parameter int SENDER_PERIOD = SENDER_PERIOD_DEFAULT,
  parameter int DEPTH_LOG     = DEPTH_LOG_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in,
  input  logic       in_valid,
  output logic       full,
  output logic       busy,
  output logic       overflow,
  output logic       tx
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] DEPTH_CNT = {1'b1, {DEPTH_LOG{1'b0}}};

  logic [7:0]           mem [0:DEPTH-1];
  logic [DEPTH_LOG-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG:0]   count;
  logic                 empty, push, pop, ready, active;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  // full is taken before any pop, so a write while full is always rejected.
  assign push  = in_valid && !full;
  assign pop   = !empty && ready;
  assign busy  = active || !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG'(1);
      case ({push, pop})
        2'b10:   count <= count + (DEPTH_LOG+1)'(1);
        2'b01:   count <= count - (DEPTH_LOG+1)'(1);
        default: count <= count;
      endcase
      if (in_valid && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in;
  end

  sender #(
    .SENDER_PERIOD(SENDER_PERIOD)
  ) u_sender (
    .clk    (clk),
    .reset  (reset),
    .data   (mem[rd_ptr]),
    .valid  (!empty),
    .ready  (ready),
    .active (active),
    .tx     (tx)
  );

endmodule

// File: tb/tb_sender_wrapper.sv
// tb/tb_sender_wrapper.sv - self-checking bench: line waveform model and frame decoder against the wrapper
module tb_sender_wrapper;

  localparam int P  = 4;
  localparam int DL = 2;
  localparam int FRAME = 10 * P;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_b = 8'h00;
  logic       in_valid = 1'b0;
  logic       full, busy, overflow, tx;

  int checks = 0;
  int errors = 0;

  logic       line_q[$];
  logic       busy_q[$];
  logic [7:0] dec_b[$];
  int         dec_s[$];

  sender_wrapper #(
    .SENDER_PERIOD(P),
    .DEPTH_LOG    (DL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in_b),
    .in_valid (in_valid),
    .full     (full),
    .busy     (busy),
    .overflow (overflow),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    line_q.push_back(tx);
    busy_q.push_back(busy);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count samples that differ from an ideal 8N1 frame of byte b starting at sample s.
  function automatic int frame_errs(int s, logic [7:0] b);
    int n = 0;
    logic bit_v;
    if (s + FRAME > line_q.size()) return 999;
    for (int k = 0; k < 10; k++) begin
      bit_v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      for (int j = 0; j < P; j++)
        if (line_q[s + k*P + j] !== bit_v) n++;
    end
    return n;
  endfunction

  // Receiver-style decode: find start bit, sample each bit at its centre.
  task automatic decode(input int from);
    int i;
    logic [7:0] b;
    dec_b.delete();
    dec_s.delete();
    i = from;
    while (i + FRAME <= line_q.size()) begin
      if (line_q[i] === 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = line_q[i + (k+1)*P + P/2];
        dec_b.push_back(b);
        dec_s.push_back(i);
        i += FRAME;
      end else begin
        i++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_one(input logic [7:0] b);
    in_b = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", busy, 1'b0);
    tick();
    tick();
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] r[5];
  int m, m2, gap, burst;
  logic exp_ovf;

  initial begin
    // Reset applied with no clock edge
    #2 reset = 1'b1;
    #1;
    check("reset_tx", tx, 1'b1);
    check("reset_full", full, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_ovf", overflow, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    tick();

    // Single byte 0x41: exact waveform and busy timing
    write_one(8'h41);
    m = line_q.size();
    repeat (45) tick();
    check("single_pre_idle", line_q[m], 1'b1);
    check("single_frame", frame_errs(m + 1, 8'h41), 0);
    check("single_busy_last", busy_q[m + 40], 1'b1);
    check("single_busy_drop", busy_q[m + 41], 1'b0);

    // Back-to-back frames, no idle gap
    in_b = 8'h00; in_valid = 1'b1; tick();
    m = line_q.size();
    in_b = 8'hFF; tick();
    in_b = 8'h55; tick();
    in_valid = 1'b0;
    repeat (130) tick();
    check("b2b_frame0", frame_errs(m + 1, 8'h00), 0);
    check("b2b_frame1", frame_errs(m + 41, 8'hFF), 0);
    check("b2b_frame2", frame_errs(m + 81, 8'h55), 0);
    decode(m);
    check("b2b_count", dec_b.size(), 3);
    if (dec_b.size() == 3) begin
      check("b2b_byte0", dec_b[0], 8'h00);
      check("b2b_byte1", dec_b[1], 8'hFF);
      check("b2b_byte2", dec_b[2], 8'h55);
      check("b2b_gap", dec_s[2] - dec_s[0], 2 * FRAME);
    end

    // Full and overflow with a 4-deep FIFO
    pulse_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_b = 8'(k + 1);
      tick();
      if (k == 0) m = line_q.size();
      check($sformatf("fill_full_%0d", k), full, (k >= 4) ? 1'b1 : 1'b0);
      check($sformatf("fill_ovf_%0d", k), overflow, (k == 5) ? 1'b1 : 1'b0);
    end
    in_valid = 1'b0;
    wait_idle(400);
    decode(m);
    check("fill_count", dec_b.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < dec_b.size()) check($sformatf("fill_byte_%0d", k), dec_b[k], 8'(k + 1));
    check("fill_ovf_sticky", overflow, 1'b1);

    // Write while full on the edge that ends a stop bit
    pulse_reset();
    for (int k = 0; k < 5; k++) r[k] = 8'($urandom);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_b = r[k];
      tick();
      if (k == 0) m = line_q.size();
    end
    in_valid = 1'b0;
    repeat (36) tick();
    check("pp_full_before", full, 1'b1);
    check("pp_ovf_before", overflow, 1'b0);
    in_b = 8'($urandom);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("pp_full_after", full, 1'b0);
    check("pp_ovf_after", overflow, 1'b1);
    wait_idle(400);
    decode(m);
    check("pp_count", dec_b.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < dec_b.size()) check($sformatf("pp_byte_%0d", k), dec_b[k], r[k]);

    // Reset during data bit 3 of 0xA5, then a clean frame of 0x3C
    pulse_reset();
    write_one(8'hA5);
    repeat (18) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_tx", tx, 1'b1);
    check("mid_busy", busy, 1'b0);
    check("mid_full", full, 1'b0);
    check("mid_ovf", overflow, 1'b0);
    #1 reset = 1'b0;
    tick();
    write_one(8'h3C);
    m2 = line_q.size();
    repeat (45) tick();
    check("mid_frame", frame_errs(m2 + 1, 8'h3C), 0);
    decode(m2);
    check("mid_count", dec_b.size(), 1);

    // Random bursts against a queue model of accepted bytes
    pulse_reset();
    exp_q.delete();
    exp_ovf = 1'b0;
    m = line_q.size();
    for (int it = 0; it < 12; it++) begin
      gap = $urandom_range(0, 60);
      repeat (gap) tick();
      burst = $urandom_range(1, 3);
      for (int k = 0; k < burst; k++) begin
        in_b = 8'($urandom);
        in_valid = 1'b1;
        if (full === 1'b0) exp_q.push_back(in_b);
        else exp_ovf = 1'b1;
        tick();
      end
      in_valid = 1'b0;
    end
    wait_idle(3000);
    decode(m);
    check("rand_count", dec_b.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      if (k < dec_b.size()) check($sformatf("rand_byte_%0d", k), dec_b[k], exp_q[k]);
    check("rand_ovf", overflow, exp_ovf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
